centroid_moment_acc: RTL and testbench

- Upstream feeder of the divider control stage in the eye-tracker centroid path.
- Scans each camera frame and selects "dark" pixels (pupil candidates) by comparing each pixel against a threshold.
- For the selected pixels it accumulates the first-order moments SX = Σx and SY = Σy, plus the pixel count N.
- At frame end it latches SX, SY and N as stable dividend/divisor sources and raises a trigger level; the divider control detects that trigger on its rising edge.

---
 rtl/centroid_moment_acc_if.sv | 28 ++
 rtl/centroid_moment_acc.sv | 150 +++++++++++++++
 tb/tb_centroid_moment_acc.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/centroid_moment_acc_if.sv
// rtl/centroid_moment_acc_if.sv - camera pixel/frame stream bundle feeding the moment accumulator
interface centroid_moment_acc_if #(
  parameter int PIX_WIDTH = 8
);
  logic                 iFRAME_START;
  logic                 iFRAME_END;
  logic                 iLINE_END;
  logic                 iPIX_VALID;
  logic [PIX_WIDTH-1:0] iPIXEL;

  // camera-side source of the stream
  modport master (
    output iFRAME_START,
    output iFRAME_END,
    output iLINE_END,
    output iPIX_VALID,
    output iPIXEL
  );

  // accumulator-side sink of the stream
  modport slave (
    input iFRAME_START,
    input iFRAME_END,
    input iLINE_END,
    input iPIX_VALID,
    input iPIXEL
  );
endinterface

// File: rtl/centroid_moment_acc.sv
// rtl/centroid_moment_acc.sv - dark-pixel first-moment accumulator with frame-end latch and divider trigger
module centroid_moment_acc #(
  parameter int H_WIDTH     = 10,
  parameter int V_WIDTH     = 10,
  parameter int PIX_WIDTH   = 8,
  parameter int SUM_WIDTH   = 32,
  parameter int CNT_WIDTH   = 20,
  parameter int TRIG_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  centroid_moment_acc_if.slave pix,
  input  logic [PIX_WIDTH-1:0] iTHRESH,
  input  logic                 iDIV_BUSY,
  input  logic                 iCLR_ERR,
  output logic [SUM_WIDTH-1:0] oSUM_X,
  output logic [SUM_WIDTH-1:0] oSUM_Y,
  output logic [CNT_WIDTH-1:0] oCOUNT,
  output logic                 oTRIG,
  output logic                 oNO_TARGET,
  output logic                 oSAT,
  output logic                 oOVERRUN
);

  localparam int TW = (TRIG_CYCLES > 2) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t               state_q, state_d;
  logic [H_WIDTH-1:0]   x_q;
  logic [V_WIDTH-1:0]   y_q;
  logic [SUM_WIDTH-1:0] sum_x_q, sum_y_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 frame_sat_q;
  logic [TW-1:0]        trig_cnt_q;

  logic                 in_accum;
  logic                 pix_qual;
  logic [SUM_WIDTH:0]   sx_wide, sy_wide;
  logic                 cnt_full;
  logic [SUM_WIDTH-1:0] sx_acc, sy_acc;
  logic [CNT_WIDTH-1:0] cnt_acc;
  logic                 sat_acc;
  logic                 frame_end_acc;
  logic                 frame_empty;
  logic                 do_latch, do_drop, do_no_tgt;

  // next frame state; a start always (re)enters ACCUM, even on the same cycle as an end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pix.iFRAME_START) state_d = S_ACCUM;
      S_ACCUM: begin
        if (pix.iFRAME_START)    state_d = S_ACCUM;
        else if (pix.iFRAME_END) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // this-cycle accumulator values including the current pixel, so a frame-end pixel lands in its frame
  always_comb begin
    in_accum      = (state_q == S_ACCUM);
    pix_qual      = in_accum && pix.iPIX_VALID && (pix.iPIXEL <= iTHRESH);
    sx_wide       = {1'b0, sum_x_q} + (SUM_WIDTH+1)'(x_q);
    sy_wide       = {1'b0, sum_y_q} + (SUM_WIDTH+1)'(y_q);
    cnt_full      = &cnt_q;
    sx_acc        = sum_x_q;
    sy_acc        = sum_y_q;
    cnt_acc       = cnt_q;
    sat_acc       = frame_sat_q;
    if (pix_qual) begin
      sx_acc  = sx_wide[SUM_WIDTH] ? '1 : sx_wide[SUM_WIDTH-1:0];
      sy_acc  = sy_wide[SUM_WIDTH] ? '1 : sy_wide[SUM_WIDTH-1:0];
      cnt_acc = cnt_full ? cnt_q : cnt_q + 1'b1;
      sat_acc = frame_sat_q | sx_wide[SUM_WIDTH] | sy_wide[SUM_WIDTH] | cnt_full;
    end
    frame_end_acc = in_accum && pix.iFRAME_END;
    frame_empty   = (cnt_acc == '0);
    do_no_tgt     = frame_end_acc && frame_empty;
    do_drop       = frame_end_acc && !frame_empty && (iDIV_BUSY || oTRIG);
    do_latch      = frame_end_acc && !frame_empty && !iDIV_BUSY && !oTRIG;
  end

  // moment accumulators; a frame start discards whatever was gathered so far
  always_ff @(posedge CLK) begin
    if (RST || pix.iFRAME_START) begin
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      cnt_q       <= '0;
      frame_sat_q <= 1'b0;
    end else if (in_accum) begin
      sum_x_q     <= sx_acc;
      sum_y_q     <= sy_acc;
      cnt_q       <= cnt_acc;
      frame_sat_q <= sat_acc;
    end
  end

  // pixel coordinates; line end beats the column increment, both wrap naturally
  always_ff @(posedge CLK) begin
    if (RST || pix.iFRAME_START) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix.iLINE_END) begin
      x_q <= '0;
      y_q <= y_q + 1'b1;
    end else if (pix.iPIX_VALID) begin
      x_q <= x_q + 1'b1;
    end
  end

  // result registers, trigger pulse and sticky overrun flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      oSUM_X     <= '0;
      oSUM_Y     <= '0;
      oCOUNT     <= '0;
      oSAT       <= 1'b0;
      oNO_TARGET <= 1'b0;
      oTRIG      <= 1'b0;
      trig_cnt_q <= '0;
      oOVERRUN   <= 1'b0;
    end else begin
      if (do_latch) begin
        oSUM_X     <= sx_acc;
        oSUM_Y     <= sy_acc;
        oCOUNT     <= cnt_acc;
        oSAT       <= sat_acc;
        oNO_TARGET <= 1'b0;
        oTRIG      <= 1'b1;
        trig_cnt_q <= TRIG_LAST;
      end else begin
        if (do_no_tgt) oNO_TARGET <= 1'b1;
        if (trig_cnt_q != '0) trig_cnt_q <= trig_cnt_q - 1'b1;
        else                  oTRIG      <= 1'b0;
      end
      if (do_drop)       oOVERRUN <= 1'b1;
      else if (iCLR_ERR) oOVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_centroid_moment_acc.sv
// tb/tb_centroid_moment_acc.sv - randomized self-checking bench for centroid_moment_acc
module tb_centroid_moment_acc;
  localparam int TRIG_CYCLES = 4;
  localparam int CNT_MAX     = (1 << 20) - 1;
  localparam int CNT4_MAX    = 15;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  iTHRESH;
  logic        iDIV_BUSY, iCLR_ERR;
  logic [31:0] sum_x_a, sum_y_a, sum_x_b, sum_y_b;
  logic [19:0] count_a;
  logic [3:0]  count_b;
  logic        trig_a, trig_b, nt_a, nt_b, sat_a, sat_b, ovr_a, ovr_b;

  centroid_moment_acc_if #(.PIX_WIDTH(8)) pif ();

  centroid_moment_acc dut_a (
    .CLK(CLK), .RST(RST), .pix(pif), .iTHRESH(iTHRESH), .iDIV_BUSY(iDIV_BUSY), .iCLR_ERR(iCLR_ERR),
    .oSUM_X(sum_x_a), .oSUM_Y(sum_y_a), .oCOUNT(count_a), .oTRIG(trig_a),
    .oNO_TARGET(nt_a), .oSAT(sat_a), .oOVERRUN(ovr_a)
  );

  centroid_moment_acc #(.CNT_WIDTH(4)) dut_b (
    .CLK(CLK), .RST(RST), .pix(pif), .iTHRESH(iTHRESH), .iDIV_BUSY(iDIV_BUSY), .iCLR_ERR(iCLR_ERR),
    .oSUM_X(sum_x_b), .oSUM_Y(sum_y_b), .oCOUNT(count_b), .oTRIG(trig_b),
    .oNO_TARGET(nt_b), .oSAT(sat_b), .oOVERRUN(ovr_b)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: expected visible outputs
  longint exp_sx, exp_sy, exp_cnt, exp_cnt4;
  bit     exp_sat, exp_sat4, exp_nt, exp_ovr;
  int     last_latch = -1000;
  bit     latch_pending, ovr_set_now, clr_at_end;
  bit [7:0] pix [8][8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit trig_now();
    return (cyc - last_latch) >= 0 && (cyc - last_latch) < TRIG_CYCLES;
  endfunction

  task automatic check_all();
    check_eq("sum_x_a", sum_x_a, exp_sx);
    check_eq("sum_y_a", sum_y_a, exp_sy);
    check_eq("count_a", count_a, exp_cnt);
    check_eq("sum_x_b", sum_x_b, exp_sx);
    check_eq("sum_y_b", sum_y_b, exp_sy);
    check_eq("count_b", count_b, exp_cnt4);
    check_eq("trig_a", trig_a, trig_now());
    check_eq("trig_b", trig_b, trig_now());
    check_eq("no_tgt_a", nt_a, exp_nt);
    check_eq("no_tgt_b", nt_b, exp_nt);
    check_eq("sat_a", sat_a, exp_sat);
    check_eq("sat_b", sat_b, exp_sat4);
    check_eq("ovr_a", ovr_a, exp_ovr);
    check_eq("ovr_b", ovr_b, exp_ovr);
  endtask

  task automatic tick();
    if (iCLR_ERR && !ovr_set_now) exp_ovr = 0;
    @(posedge CLK);
    #1;
    cyc++;
    if (latch_pending) last_latch = cyc;
    latch_pending = 0;
    ovr_set_now   = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    exp_sx = 0; exp_sy = 0; exp_cnt = 0; exp_cnt4 = 0;
    exp_sat = 0; exp_sat4 = 0; exp_nt = 0; exp_ovr = 0;
    last_latch = -1000; latch_pending = 0; ovr_set_now = 0;
  endtask

  task automatic frame_decide(input longint sx, input longint sy, input longint n, input bit busy);
    if (n == 0) begin
      exp_nt = 1;
    end else if (busy || trig_now()) begin
      exp_ovr = 1;
      ovr_set_now = 1;
    end else begin
      exp_sx   = sx;
      exp_sy   = sy;
      exp_cnt  = (n > CNT_MAX) ? CNT_MAX : n;
      exp_cnt4 = (n > CNT4_MAX) ? CNT4_MAX : n;
      exp_sat  = (n > CNT_MAX);
      exp_sat4 = (n > CNT4_MAX);
      exp_nt   = 0;
      latch_pending = 1;
    end
  endtask

  task automatic fill_rand(input int w, input int h, input int pct);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        pix[y][x] = ($urandom_range(0, 99) < pct) ? 8'($urandom_range(0, iTHRESH))
                                                 : 8'($urandom_range(iTHRESH + 1, 255));
  endtask

  task automatic fill_const(input int w, input int h, input bit [7:0] v);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        pix[y][x] = v;
  endtask

  task automatic do_frame(input int w, input int h, input bit busy, input bit send_start, input bit start_next);
    longint sx = 0, sy = 0, n = 0;
    iDIV_BUSY = busy;
    if (send_start) begin
      pif.iFRAME_START = 1;
      tick();
      pif.iFRAME_START = 0;
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if ($urandom_range(0, 3) == 0) tick();
        pif.iPIX_VALID = 1;
        pif.iPIXEL     = pix[y][x];
        if (pix[y][x] <= iTHRESH) begin
          sx += x; sy += y; n++;
        end
        pif.iLINE_END = (x == w - 1) && (y != h - 1);
        if (x == w - 1 && y == h - 1) begin
          pif.iFRAME_END   = 1;
          pif.iFRAME_START = start_next;
          iCLR_ERR         = clr_at_end;
          frame_decide(sx, sy, n, busy);
        end
        tick();
        pif.iPIX_VALID = 0; pif.iLINE_END = 0; pif.iFRAME_END = 0;
        pif.iFRAME_START = 0; iCLR_ERR = 0;
      end
    end
    iDIV_BUSY = 0;
  endtask

  initial begin
    RST = 1; iTHRESH = 50; iDIV_BUSY = 0; iCLR_ERR = 0; clr_at_end = 0;
    pif.iFRAME_START = 0; pif.iFRAME_END = 0; pif.iLINE_END = 0;
    pif.iPIX_VALID = 0; pif.iPIXEL = 0;
    model_reset();
    tick();
    tick();
    RST = 0;
    idle(2);

    // two dark pixels at (1,0) and (3,2) in a 4x3 frame
    fill_const(4, 3, 8'd200);
    pix[0][1] = 8'd10;
    pix[2][3] = 8'd50;
    do_frame(4, 3, 0, 1, 0);
    check_eq("tp_sx", sum_x_a, 64'd4);
    check_eq("tp_sy", sum_y_a, 64'd2);
    check_eq("tp_cnt", count_a, 64'd2);
    check_eq("tp_trig", trig_a, 1'b1);
    idle(6);

    // no dark pixels: outputs keep the previous frame
    fill_const(4, 3, 8'd200);
    do_frame(4, 3, 0, 1, 0);
    check_eq("nt_flag", nt_a, 1'b1);
    check_eq("nt_hold_sx", sum_x_a, 64'd4);
    check_eq("nt_hold_cnt", count_a, 64'd2);
    idle(3);

    // frame end in IDLE is ignored
    pif.iFRAME_END = 1;
    tick();
    pif.iFRAME_END = 0;
    idle(2);

    // divider busy -> overrun, clear, then set+clear collision
    fill_const(2, 2, 8'd5);
    do_frame(2, 2, 1, 1, 0);
    check_eq("ovr_set", ovr_a, 1'b1);
    check_eq("ovr_hold_cnt", count_a, 64'd2);
    iCLR_ERR = 1;
    tick();
    iCLR_ERR = 0;
    check_eq("ovr_clr", ovr_a, 1'b0);
    clr_at_end = 1;
    do_frame(2, 2, 1, 1, 0);
    clr_at_end = 0;
    check_eq("ovr_set_wins", ovr_a, 1'b1);
    idle(2);

    // 20 dark pixels saturate the 4-bit counter
    fill_const(5, 4, 8'd10);
    do_frame(5, 4, 0, 1, 0);
    check_eq("sat_cnt4", count_b, 64'd15);
    check_eq("sat_flag4", sat_b, 1'b1);
    check_eq("sat_cnt20", count_a, 64'd20);
    idle(6);
    fill_const(2, 2, 8'd200);
    pix[1][1] = 8'd0;
    do_frame(2, 2, 0, 1, 0);
    check_eq("sat_clear4", sat_b, 1'b0);
    idle(6);

    // frame end + start collide on a dark pixel at (2,1)
    fill_const(3, 2, 8'd200);
    pix[0][0] = 8'd1;
    pix[1][2] = 8'd1;
    do_frame(3, 2, 0, 1, 1);
    check_eq("coin_cnt", count_a, 64'd2);
    check_eq("coin_sx", sum_x_a, 64'd2);
    check_eq("coin_sy", sum_y_a, 64'd1);
    idle(6);
    fill_const(2, 2, 8'd200);
    pix[1][1] = 8'd1;
    do_frame(2, 2, 0, 0, 0);
    check_eq("coin_next_cnt", count_a, 64'd1);
    idle(6);

    // reset mid-frame after five dark pixels
    pif.iFRAME_START = 1;
    tick();
    pif.iFRAME_START = 0;
    for (int i = 0; i < 5; i++) begin
      pif.iPIX_VALID = 1; pif.iPIXEL = 8'd3;
      tick();
    end
    pif.iPIX_VALID = 0;
    RST = 1;
    model_reset();
    tick();
    RST = 0;
    check_eq("rst_cnt", count_a, 64'd0);
    check_eq("rst_sx", sum_x_a, 64'd0);
    fill_const(3, 2, 8'd200);
    pix[0][0] = 8'd0;
    do_frame(3, 2, 0, 1, 0);
    check_eq("rst_next_cnt", count_a, 64'd1);
    check_eq("rst_next_sx", sum_x_a, 64'd0);
    check_eq("rst_next_sy", sum_y_a, 64'd0);

    // randomized frames against the model
    for (int f = 0; f < 60; f++) begin
      bit sn;
      iTHRESH = 8'($urandom_range(1, 254));
      fill_rand($urandom_range(1, 8), $urandom_range(1, 6), $urandom_range(0, 100));
      sn = ($urandom_range(0, 3) == 0);
      do_frame($urandom_range(1, 8), $urandom_range(1, 6), ($urandom_range(0, 5) == 0), 1, sn);
      if ($urandom_range(0, 4) == 0) begin
        iCLR_ERR = 1;
        tick();
        iCLR_ERR = 0;
      end
      idle($urandom_range(0, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
